// File: rtl/dpcm_diff_encoder.sv
// dpcm_diff_encoder
// Encoder side of a sample-difference (DPCM) link. Emits d[n] = x[n] - r[n-1],
// where r is the decoder's running reconstruction r[n] = r[n-1] + d[n].
// The encoder keeps its own copy of r, built from the possibly clipped
// difference it actually sent. A saturated step therefore never desynchronises
// the decoder. Key samples carry the absolute value and reload the decoder.
// A single output register with valid/ready on both sides.
// ce=0 freezes every register and blocks input.

module dpcm_diff_encoder #(
   parameter int W = 31
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ce,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_sample,
   input  logic         in_key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_diff,
   output logic         out_key,
   output logic         out_sat
);

   // Largest and smallest representable W-bit signed differences.
   localparam logic [W-1:0] diff_max = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] diff_min = {1'b1, {(W-1){1'b0}}};

   logic [W-1:0]   recon;      // decoder's reconstruction of the last sample
   logic           first;      // no key sent since reset: next sample must be a key
   logic           accept;
   logic           key;
   logic signed [W:0] t;       // unclipped difference, one guard bit
   logic [W-1:0]   diff_next;
   logic           sat_next;

   // Handshake: the output slot is free when it is empty or being popped now.
   always_comb begin
      in_ready = ce & ~rst & (~out_valid | out_ready);
      accept   = in_valid & in_ready;
   end

   // Difference, clipping and key selection for the sample being offered.
   // NOTE: every output of this block gets a default first so no path leaves
   // a variable unassigned, which would infer a latch.
   always_comb begin
      key       = in_key | first;
      t         = $signed({in_sample[W-1], in_sample}) - $signed({recon[W-1], recon});
      diff_next = t[W-1:0];
      sat_next  = 1'b0;
      if (key) begin
         diff_next = in_sample;
      end else if (t[W:W-1] == 2'b01) begin
         // Positive overflow of the W-bit range.
         diff_next = diff_max;
         sat_next  = 1'b1;
      end else if (t[W:W-1] == 2'b10) begin
         // Negative overflow of the W-bit range.
         diff_next = diff_min;
         sat_next  = 1'b1;
      end
   end

   // Output register and reconstruction tracker; rst wins over ce and handshakes.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_diff  <= '0;
         out_key   <= 1'b0;
         out_sat   <= 1'b0;
         recon     <= '0;
         first     <= 1'b1;
      end else if (ce) begin
         if (accept) begin
            out_valid <= 1'b1;
            out_diff  <= diff_next;
            out_key   <= key;
            out_sat   <= sat_next;
            first     <= 1'b0;
            // Clipping keeps recon + diff inside the W-bit range, so no wrap.
            recon     <= key ? in_sample : recon + diff_next;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_dpcm_diff_encoder.sv
// tb_dpcm_diff_encoder
// Directed scenarios followed by a randomized stream. The expected output stage
// is predicted from the arithmetic rules: an unbounded-integer difference is
// clamped to the signed range. A scoreboard rebuilds the decoder's
// reconstruction from every popped output.

module tb_dpcm_diff_encoder;

   localparam int W = 31;
   localparam longint MAXV = (longint'(1) << (W-1)) - 1;
   localparam longint MINV = -(longint'(1) << (W-1));

   logic         clk;
   logic         rst;
   logic         ce;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_sample;
   logic         in_key;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_diff;
   logic         out_key;
   logic         out_sat;

   dpcm_diff_encoder #(.W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .ce        (ce),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sample (in_sample),
      .in_key    (in_key),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_diff  (out_diff),
      .out_key   (out_key),
      .out_sat   (out_sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      longint diff;
      bit     key;
      bit     sat;
      longint x;
      longint recon;
   } res_t;

   int     checks   = 0;
   int     failures = 0;

   // Reference model state
   res_t   cur;
   bit     exp_valid;
   longint m_recon;
   bit     m_first;

   // Scoreboard state (built only from popped DUT outputs)
   longint acc;
   bit     clean;
   longint last_pop;

   task automatic check(input string tag, input logic signed [63:0] got,
                        input logic signed [63:0] want);
      checks++;
      assert (got === want) else begin
         failures++;
         $error("FAIL %s: got %0d expected %0d", tag, got, want);
      end
   endtask

   function automatic longint wrapw(input longint v);
      longint r;
      r = v & ((longint'(1) << W) - 1);
      if (r > MAXV) r = r - (longint'(1) << W);
      return r;
   endfunction

   function automatic longint sx(input logic [W-1:0] v);
      return longint'($signed(v));
   endfunction

   task automatic model_reset();
      exp_valid = 1'b0;
      cur       = '{0, 0, 0, 0, 0};
      m_recon   = 0;
      m_first   = 1'b1;
   endtask

   // One clock cycle: drive, compare against model, advance model, clock.
   task automatic cyc(input bit v, input longint x, input bit k,
                      input bit ordy, input bit c, input bit r);
      bit     exp_rdy;
      bit     pop;
      bit     push;
      res_t   n;
      longint t;
      in_valid  = v;
      in_sample = x[W-1:0];
      in_key    = k;
      out_ready = ordy;
      ce        = c;
      rst       = r;
      #1;
      check("out_valid", out_valid, exp_valid);
      check("out_diff", sx(out_diff), cur.diff);
      check("out_key", out_key, cur.key);
      check("out_sat", out_sat, cur.sat);
      exp_rdy = c & ~r & (~exp_valid | ordy);
      check("in_ready", in_ready, exp_rdy);
      pop  = exp_valid & ordy & c & ~r;
      push = v & exp_rdy;
      if (r) begin
         model_reset();
      end else begin
         if (pop) begin
            if (cur.key) begin
               acc   = cur.diff;
               clean = 1'b1;
            end else begin
               acc = wrapw(acc + cur.diff);
            end
            if (cur.sat) clean = 1'b0;
            check("sb_recon", acc, cur.recon);
            if (clean) check("sb_x", acc, cur.x);
            last_pop = cur.diff;
         end
         if (push) begin
            n.x   = wrapw(x);
            n.key = k | m_first;
            if (n.key) begin
               n.diff  = n.x;
               n.sat   = 1'b0;
               m_recon = n.x;
               m_first = 1'b0;
            end else begin
               t = n.x - m_recon;
               if (t > MAXV) begin
                  n.diff = MAXV;
                  n.sat  = 1'b1;
               end else if (t < MINV) begin
                  n.diff = MINV;
                  n.sat  = 1'b1;
               end else begin
                  n.diff = t;
                  n.sat  = 1'b0;
               end
               m_recon = m_recon + n.diff;
            end
            n.recon   = m_recon;
            cur       = n;
            exp_valid = 1'b1;
         end else if (pop) begin
            exp_valid = 1'b0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   function automatic longint rand_x();
      bit [31:0] r32;
      r32 = $urandom;
      if ($urandom_range(0, 3) == 0) return wrapw(longint'(r32));
      return wrapw(m_recon + longint'($urandom_range(0, 200)) - 100);
   endfunction

   initial begin
      acc      = 0;
      clean    = 1'b0;
      last_pop = 0;
      model_reset();

      // Power-up reset before any comparison.
      rst = 1'b1; ce = 1'b1; in_valid = 1'b0; in_sample = '0; in_key = 1'b0; out_ready = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;

      // 1: basic differences, first sample forced to key.
      cyc(0, 0, 0, 1, 1, 1);
      cyc(1, 100, 0, 1, 1, 0);
      cyc(1, 103, 0, 1, 1, 0);
      cyc(1, 99, 0, 1, 1, 0);
      cyc(0, 0, 0, 1, 1, 0);
      check("t1_recon", acc, 99);
      check("t1_last", last_pop, -4);

      // 2: range boundaries and negative saturation.
      cyc(0, 0, 0, 1, 1, 1);
      cyc(1, 0, 0, 1, 1, 0);
      cyc(1, MAXV, 0, 1, 1, 0);
      cyc(1, MINV, 0, 1, 1, 0);
      check("t2_sat", out_sat, 1);
      check("t2_diff", sx(out_diff), MINV);
      cyc(1, MINV, 0, 1, 1, 0);
      cyc(0, 0, 0, 1, 1, 0);
      check("t2_last", last_pop, MINV + 1);
      check("t2_recon", acc, MINV);

      // 3: backpressure for 5 cycles with input offered, then stream.
      cyc(1, 1000, 0, 0, 1, 0);
      for (int i = 0; i < 5; i++) cyc(1, 1000 + 7 * i, 0, 0, 1, 0);
      for (int i = 0; i < 8; i++) cyc(1, rand_x(), 0, 1, 1, 0);

      // 4: ce low mid-stream with valid and ready high.
      for (int i = 0; i < 3; i++) cyc(1, rand_x(), 0, 1, 0, 0);
      for (int i = 0; i < 4; i++) cyc(1, rand_x(), 0, 1, 1, 0);
      cyc(0, 0, 0, 1, 1, 0);

      // 5: forced key mid-stream.
      cyc(0, 0, 0, 1, 1, 1);
      cyc(1, 20, 0, 1, 1, 0);
      cyc(1, 500, 1, 1, 1, 0);
      check("t5_key", out_key, 1);
      check("t5_diff", sx(out_diff), 500);
      cyc(1, 510, 0, 1, 1, 0);
      cyc(0, 0, 0, 1, 1, 0);
      check("t5_last", last_pop, 10);

      // 6: reset while an output is held; next sample becomes a key.
      cyc(1, 777, 0, 0, 1, 0);
      cyc(1, 800, 0, 0, 1, 1);
      check("t6_valid", out_valid, 0);
      cyc(1, 900, 0, 1, 1, 0);
      check("t6_key", out_key, 1);
      cyc(0, 0, 0, 1, 1, 0);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         cyc($urandom_range(0, 3) != 0, rand_x(), $urandom_range(0, 15) == 0,
             $urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0,
             $urandom_range(0, 63) == 0);
      end
      cyc(0, 0, 0, 1, 1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
